// File: rtl/bit_shuffle_stage.sv
// rtl/bit_shuffle_stage.sv - registered bit-permutation stage with a runtime-writable table
// Optional per-bit output mask is compiled in when BIT_SHUFFLE_MASK_EN is defined.
module bit_shuffle_stage #(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [IDXW-1:0]  cfg_sel,
  output logic             cfg_err,
`ifdef BIT_SHUFFLE_MASK_EN
  input  logic             cfg_mask_we,
  input  logic [WIDTH-1:0] cfg_mask,
`endif
  output logic [15:0]      beat_count
);

  localparam logic [IDXW:0] WIDTH_L = (IDXW+1)'(WIDTH);

  logic [IDXW-1:0]  perm_q [WIDTH];
  logic [IDXW-1:0]  perm_d [WIDTH];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             cfg_err_q, cfg_err_d;
  logic [15:0]      count_q, count_d;
  logic [WIDTH-1:0] shuffled, masked;
  logic             in_range, accept, xfer;

  assign in_range = ({1'b0, cfg_idx} < WIDTH_L) && ({1'b0, cfg_sel} < WIDTH_L);
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  // Beats use the table as it stands before this edge's cfg write lands.
  always_comb begin
    shuffled = '0;
    for (int i = 0; i < WIDTH; i++) begin
      shuffled[i] = |(in_data & (WIDTH'(1) << perm_q[i]));
    end
  end

`ifdef BIT_SHUFFLE_MASK_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  assign mask_d = cfg_mask_we ? cfg_mask : mask_q;
  assign masked = shuffled & mask_q;
`else
  assign masked = shuffled;
`endif

  always_comb begin
    perm_d = perm_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cfg_we && in_range && (cfg_idx == IDXW'(i))) begin
        perm_d[i] = cfg_sel;
      end
    end
    cfg_err_d   = cfg_we && !in_range;
    out_valid_d = accept ? 1'b1 : (xfer ? 1'b0 : out_valid_q);
    out_data_d  = accept ? masked : out_data_q;
    count_d     = count_q + 16'(xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        perm_q[i] <= IDXW'(i);
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      count_q     <= '0;
`ifdef BIT_SHUFFLE_MASK_EN
      mask_q      <= '1;
`endif
    end else begin
      perm_q      <= perm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      count_q     <= count_d;
`ifdef BIT_SHUFFLE_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign cfg_err    = cfg_err_q;
  assign beat_count = count_q;

endmodule

// File: tb/tb_bit_shuffle_stage.sv
// tb/tb_bit_shuffle_stage.sv - self-checking bench for bit_shuffle_stage (WIDTH=8, IDXW=4)
// Index fields are one bit wider than needed so out-of-range cfg values can be driven.
module tb_bit_shuffle_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, cfg_we = 1'b0, cfg_mask_we = 1'b0;
  logic [7:0]  in_data = '0, cfg_mask = '0;
  logic [3:0]  cfg_idx = '0, cfg_sel = '0;
  logic        in_ready, out_valid, cfg_err;
  logic [7:0]  out_data;
  logic [15:0] beat_count;

  bit_shuffle_stage #(.WIDTH(8), .IDXW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_err(cfg_err),
`ifdef BIT_SHUFFLE_MASK_EN
    .cfg_mask_we(cfg_mask_we), .cfg_mask(cfg_mask),
`endif
    .beat_count(beat_count)
  );

  int checks = 0, failures = 0;

  // Reference state: the table, the mask, and what the output register should hold.
  int          m_perm [8];
  logic [7:0]  m_mask;
  bit          m_occ;
  logic [7:0]  m_data;
  logic [15:0] m_cnt;
  bit          m_err;

  function automatic logic [7:0] model_shuffle(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[m_perm[i]] & m_mask[i];
    return r;
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit ordy, input bit r, input bit chk);
    bit exp_ready, acc, xfer;
    logic [7:0] nd;
    in_valid = v; in_data = d; out_ready = ordy; rst = r;
    #1;
    exp_ready = !r && (!m_occ || ordy);
    if (chk) begin
      checks++;
      if (in_ready !== exp_ready) begin
        failures++; $display("FAIL step_in_ready got=%b exp=%b", in_ready, exp_ready);
      end
    end
    if (r) begin
      for (int i = 0; i < 8; i++) m_perm[i] = i;
      m_mask = 8'hFF; m_occ = 0; m_data = 8'h00; m_cnt = 16'h0; m_err = 0;
    end else begin
      xfer = m_occ && ordy;
      acc  = v && exp_ready;
      nd   = model_shuffle(d);
      m_err = cfg_we && (cfg_idx >= 8 || cfg_sel >= 8);
      if (cfg_we && !m_err) m_perm[cfg_idx] = int'(cfg_sel);
`ifdef BIT_SHUFFLE_MASK_EN
      if (cfg_mask_we) m_mask = cfg_mask;
`endif
      if (xfer) m_cnt = m_cnt + 16'd1;
      if (acc) begin m_occ = 1; m_data = nd; end
      else if (xfer) m_occ = 0;
    end
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_mask_we = 1'b0;
    if (chk) begin
      checks++;
      if (out_valid !== m_occ) begin
        failures++; $display("FAIL step_out_valid got=%b exp=%b", out_valid, m_occ);
      end
      if (m_occ) begin
        checks++;
        if (out_data !== m_data) begin
          failures++; $display("FAIL step_out_data got=%h exp=%h", out_data, m_data);
        end
      end
      checks++;
      if (cfg_err !== m_err) begin
        failures++; $display("FAIL step_cfg_err got=%b exp=%b", cfg_err, m_err);
      end
      checks++;
      if (beat_count !== m_cnt) begin
        failures++; $display("FAIL step_beat_count got=%h exp=%h", beat_count, m_cnt);
      end
    end
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || cfg_err !== 1'b0 || beat_count !== 16'h0) begin
      failures++; $display("FAIL reset_values got v=%b d=%h e=%b c=%h exp 0/00/0/0000", out_valid, out_data, cfg_err, beat_count);
    end
    step(1, 8'h5A, 0, 0, 1);
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_sel = 4'd5;
    step(1, 8'h33, 1, 1, 1);
    step(1, 8'h01, 1, 0, 1);
    checks++;
    if (out_data !== 8'h01) begin
      failures++; $display("FAIL reset_ignores_cfg got=%h exp=01", out_data);
    end
  endtask

  task automatic test_basic();
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'hA5, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      failures++; $display("FAIL basic_data got v=%b d=%h exp 1/a5", out_valid, out_data);
    end
    step(0, 8'h00, 1, 0, 1);
    checks++;
    if (beat_count !== 16'd1) begin
      failures++; $display("FAIL basic_count got=%h exp=0001", beat_count);
    end
  endtask

  task automatic test_reverse();
    step(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1; cfg_idx = 4'(i); cfg_sel = 4'(7 - i);
      step(0, 8'h00, 1, 0, 1);
    end
    step(1, 8'h01, 1, 0, 1);
    checks++;
    if (out_data !== 8'h80) begin
      failures++; $display("FAIL reverse_01 got=%h exp=80", out_data);
    end
    step(1, 8'h0C, 1, 0, 1);
    checks++;
    if (out_data !== 8'h30) begin
      failures++; $display("FAIL reverse_0c got=%h exp=30", out_data);
    end
  endtask

  task automatic test_backpressure();
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'h11, 0, 0, 1);
    step(1, 8'h22, 0, 0, 1);
    checks++;
    if (in_ready !== 1'b0 || out_data !== 8'h11) begin
      failures++; $display("FAIL bp_hold got rdy=%b d=%h exp 0/11", in_ready, out_data);
    end
    step(1, 8'h22, 1, 0, 1);
    checks++;
    if (out_data !== 8'h22 || beat_count !== 16'd1) begin
      failures++; $display("FAIL bp_second got d=%h c=%h exp 22/0001", out_data, beat_count);
    end
    step(0, 8'h00, 1, 0, 1);
    checks++;
    if (out_valid !== 1'b0 || beat_count !== 16'd2) begin
      failures++; $display("FAIL bp_drain got v=%b c=%h exp 0/0002", out_valid, beat_count);
    end
  endtask

  task automatic test_cfg_same_cycle();
    step(0, 8'h00, 0, 1, 1);
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_sel = 4'd3;
    step(1, 8'h08, 1, 0, 1);
    checks++;
    if (out_data !== 8'h08) begin
      failures++; $display("FAIL cfg_old_table got=%h exp=08", out_data);
    end
    step(1, 8'h08, 1, 0, 1);
    checks++;
    if (out_data !== 8'h09) begin
      failures++; $display("FAIL cfg_new_table got=%h exp=09", out_data);
    end
  endtask

  task automatic test_cfg_err();
    step(0, 8'h00, 0, 1, 1);
    cfg_we = 1'b1; cfg_idx = 4'd2; cfg_sel = 4'd8;
    step(0, 8'h00, 1, 0, 1);
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++; $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err);
    end
    cfg_we = 1'b1; cfg_idx = 4'd9; cfg_sel = 4'd0;
    step(1, 8'h04, 1, 0, 1);
    step(1, 8'h01, 1, 0, 1);
    checks++;
    if (cfg_err !== 1'b0 || out_data !== 8'h01) begin
      failures++; $display("FAIL cfg_err_clear got e=%b d=%h exp 0/01", cfg_err, out_data);
    end
  endtask

  task automatic test_random();
    step(0, 8'h00, 0, 1, 1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_we = 1'b1; cfg_idx = 4'($urandom_range(0, 9)); cfg_sel = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 15) == 0) begin
        cfg_mask_we = 1'b1; cfg_mask = 8'($urandom);
      end
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, 1);
    end
  endtask

  task automatic test_wrap();
    step(0, 8'h00, 0, 1, 1);
    for (int n = 0; n < 65536; n++) step(1, 8'(n), 1, 0, 0);
    checks++;
    if (beat_count !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_ffff got=%h exp=ffff", beat_count);
    end
    step(0, 8'h00, 1, 0, 1);
    checks++;
    if (beat_count !== 16'h0000) begin
      failures++; $display("FAIL wrap_zero got=%h exp=0000", beat_count);
    end
  endtask

  task automatic test_mask();
    step(0, 8'h00, 0, 1, 1);
`ifdef BIT_SHUFFLE_MASK_EN
    cfg_mask_we = 1'b1; cfg_mask = 8'hF0;
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'hFF, 1, 0, 1);
    checks++;
    if (out_data !== 8'hF0) begin
      failures++; $display("FAIL mask_f0 got=%h exp=f0", out_data);
    end
`else
    step(1, 8'hFF, 1, 0, 1);
    checks++;
    if (out_data !== 8'hFF) begin
      failures++; $display("FAIL mask_off got=%h exp=ff", out_data);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_backpressure();
    test_cfg_same_cycle();
    test_cfg_err();
    test_random();
    test_mask();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
